// File: rtl/u_seq_pkg.sv
// Shared constants for the microprogram sequencer: sequencing op codes and FSM state encoding.
// Optional subroutine support is selected with U_SEQ_SUBROUTINE_EN.
package u_seq_pkg;

    typedef logic [2:0] seq_op_t;

    localparam seq_op_t OP_CONT = 3'b000;
    localparam seq_op_t OP_JUMP = 3'b001;
    localparam seq_op_t OP_BRC  = 3'b010;
    localparam seq_op_t OP_WAIT = 3'b011;
    localparam seq_op_t OP_CALL = 3'b100;
    localparam seq_op_t OP_RET  = 3'b101;
    localparam seq_op_t OP_HALT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/u_seq_next_addr.sv
// Combinational next-uPC selection for the sequencer, plus the HALT flag.
// With U_SEQ_SUBROUTINE_EN undefined, CALL acts as JUMP and RET as CONT.
module u_seq_next_addr
    import u_seq_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] upc,
    input  seq_op_t           op,
    input  logic              ct,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              halt
);

    logic [ADDR_W-1:0] upc_inc;

`ifndef U_SEQ_SUBROUTINE_EN
    logic unused_ret;
    assign unused_ret = ^ret_addr;
`endif

    always_comb begin
        upc_inc   = upc + ADDR_W'(1);
        next_addr = upc_inc;
        halt      = 1'b0;
        case (op)
            OP_JUMP: next_addr = br_addr;
            OP_BRC:  next_addr = ct ? br_addr : upc_inc;
            OP_WAIT: next_addr = ct ? upc_inc : upc;
            OP_CALL: next_addr = br_addr;
`ifdef U_SEQ_SUBROUTINE_EN
            OP_RET:  next_addr = ret_addr;
`else
            OP_RET:  next_addr = upc_inc;
`endif
            OP_HALT: begin
                next_addr = '0;
                halt      = 1'b1;
            end
            default: next_addr = upc_inc;
        endcase
    end

endmodule

// File: rtl/u_sequencer.sv
// Microprogram sequencer: uPC, return register and START/DONE/ACK handshake FSM.
// Define U_SEQ_SUBROUTINE_EN to build the one-entry return register for CALL/RET.
//
// state   | meaning
// IDLE    | uPC parked at 0, waiting for START
// RUN     | executing the ROM word at ADDR each cycle
// DONE    | HALT reached, DONE held until ACK
module u_sequencer
    import u_seq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int NCOND  = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic                     ACK,
    input  logic [NCOND-1:0]         COND,
    input  logic [2:0]               SEQ_OP,
    input  logic [$clog2(NCOND)-1:0] COND_SEL,
    input  logic                     COND_POL,
    input  logic [ADDR_W-1:0]        BR_ADDR,
    output logic [ADDR_W-1:0]        ADDR,
    output logic                     RUN,
    output logic                     DONE
);

    seq_state_e        state;
    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              halt;
    logic              ct;
    logic              run_q;
    logic              done_q;

    assign ct = (COND[COND_SEL] == COND_POL);

    u_seq_next_addr #(
        .ADDR_W (ADDR_W)
    ) u_next (
        .upc       (upc),
        .op        (SEQ_OP),
        .ct        (ct),
        .br_addr   (BR_ADDR),
        .ret_addr  (ret_addr),
        .next_addr (next_addr),
        .halt      (halt)
    );

`ifdef U_SEQ_SUBROUTINE_EN
    // Single entry: a nested CALL simply overwrites the saved return address.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ret_addr <= '0;
        end else if (state == ST_RUN && SEQ_OP == OP_CALL) begin
            ret_addr <= upc + ADDR_W'(1);
        end
    end
`else
    assign ret_addr = '0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            upc    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_RUN;
                        upc   <= '0;
                        run_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state  <= ST_DONE;
                        upc    <= '0;
                        run_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        upc <= next_addr;
                    end
                end
                ST_DONE: begin
                    // ACK wins over START here; a new run needs a fresh START from IDLE.
                    if (ACK) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    upc    <= '0;
                    run_q  <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign ADDR = upc;
    assign RUN  = run_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_u_sequencer.sv
// Bench for u_sequencer: the bench plays the control ROM, keeps a reference model and checks every cycle.
// Expectations for CALL/RET follow U_SEQ_SUBROUTINE_EN.
module tb_u_sequencer;

    localparam int ADDR_W = 4;
    localparam int NCOND  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

`ifdef U_SEQ_SUBROUTINE_EN
    localparam bit SUB_EN        = 1'b1;
    localparam int EXP_AFTER_RET = 3;
`else
    localparam bit SUB_EN        = 1'b0;
    localparam int EXP_AFTER_RET = 13;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b1;
    logic              START = 1'b0;
    logic              ACK = 1'b0;
    logic [NCOND-1:0]  COND = '0;
    logic [2:0]        SEQ_OP;
    logic [1:0]        COND_SEL;
    logic              COND_POL;
    logic [ADDR_W-1:0] BR_ADDR;
    logic [ADDR_W-1:0] ADDR;
    logic              RUN;
    logic              DONE;

    logic [2:0]        rom_op  [DEPTH];
    logic [1:0]        rom_sel [DEPTH];
    logic              rom_pol [DEPTH];
    logic [ADDR_W-1:0] rom_br  [DEPTH];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference model: mode 0 idle, 1 running, 2 done
    int m_mode = 0;
    int m_pc   = 0;
    int m_ret  = 0;

    u_sequencer #(
        .ADDR_W (ADDR_W),
        .NCOND  (NCOND)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .ACK      (ACK),
        .COND     (COND),
        .SEQ_OP   (SEQ_OP),
        .COND_SEL (COND_SEL),
        .COND_POL (COND_POL),
        .BR_ADDR  (BR_ADDR),
        .ADDR     (ADDR),
        .RUN      (RUN),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    assign SEQ_OP   = rom_op[ADDR];
    assign COND_SEL = rom_sel[ADDR];
    assign COND_POL = rom_pol[ADDR];
    assign BR_ADDR  = rom_br[ADDR];

    always @(negedge RESET_N) begin
        m_mode = 0;
        m_pc   = 0;
        m_ret  = 0;
    end

    always @(posedge CLK) begin
        int op;
        bit taken;
        int inc;
        if (RESET_N) begin
            if (m_mode == 0) begin
                if (START) begin
                    m_mode = 1;
                    m_pc   = 0;
                end
            end else if (m_mode == 1) begin
                op    = int'(rom_op[m_pc]);
                taken = (COND[rom_sel[m_pc]] == rom_pol[m_pc]);
                inc   = (m_pc + 1) % DEPTH;
                if (op == 6) begin
                    m_mode = 2;
                    m_pc   = 0;
                end else if (op == 1) begin
                    m_pc = int'(rom_br[m_pc]);
                end else if (op == 2) begin
                    m_pc = taken ? int'(rom_br[m_pc]) : inc;
                end else if (op == 3) begin
                    m_pc = taken ? inc : m_pc;
                end else if (op == 4) begin
                    if (SUB_EN) m_ret = inc;
                    m_pc = int'(rom_br[m_pc]);
                end else if (op == 5) begin
                    m_pc = SUB_EN ? m_ret : inc;
                end else begin
                    m_pc = inc;
                end
            end else begin
                if (ACK) m_mode = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_addr", 32'(ADDR), 32'(m_pc));
            chk("model_run", 32'(RUN), 32'(m_mode == 1));
            chk("model_done", 32'(DONE), 32'(m_mode == 2));
        end
    end

    task automatic lit(input string name, input int addr, input int run, input int done);
        chk({name, "_addr"}, 32'(ADDR), 32'(addr));
        chk({name, "_run"}, 32'(RUN), 32'(run));
        chk({name, "_done"}, 32'(DONE), 32'(done));
        chk({name, "_mpc"}, 32'(m_pc), 32'(addr));
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_prog();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic ack_prog();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) begin
            rom_op[i]  = 3'b000;
            rom_sel[i] = 2'd0;
            rom_pol[i] = 1'b0;
            rom_br[i]  = '0;
        end
    endtask

    task automatic set_word(input int a, input logic [2:0] op, input logic [1:0] sel,
                            input logic pol, input logic [ADDR_W-1:0] br);
        rom_op[a]  = op;
        rom_sel[a] = sel;
        rom_pol[a] = pol;
        rom_br[a]  = br;
    endtask

    initial begin
        clear_rom();
        #2 RESET_N = 1'b0;
        #1 chk_en = 1'b1;
        #10;
        lit("reset", 0, 0, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        step();
        lit("idle_hold", 0, 0, 0);

        // CONT, CONT, HALT
        set_word(2, 3'b110, 2'd0, 1'b0, 4'd0);
        start_prog();
        lit("basic0", 0, 1, 0);
        step();
        lit("basic1", 1, 1, 0);
        step();
        lit("basic2", 2, 1, 0);
        step();
        lit("basic_done", 0, 0, 1);
        step();
        lit("done_hold", 0, 0, 1);
        ack_prog();
        lit("basic_ack", 0, 0, 0);

        // BRC at 3 to 9 on COND[1]==1
        clear_rom();
        set_word(3, 3'b010, 2'd1, 1'b1, 4'd9);
        set_word(4, 3'b110, 2'd0, 1'b0, 4'd0);
        set_word(9, 3'b110, 2'd0, 1'b0, 4'd0);
        COND = 4'b0010;
        start_prog();
        repeat (3) step();
        lit("brc_at3", 3, 1, 0);
        step();
        lit("brc_taken", 9, 1, 0);
        step();
        ack_prog();
        COND = 4'b0000;
        start_prog();
        repeat (3) step();
        step();
        lit("brc_not_taken", 4, 1, 0);
        step();
        lit("brc_done", 0, 0, 1);
        ack_prog();

        // WAIT at 5 on COND[0]
        clear_rom();
        set_word(5, 3'b011, 2'd0, 1'b1, 4'd0);
        set_word(6, 3'b110, 2'd0, 1'b0, 4'd0);
        start_prog();
        repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            lit("wait_stall", 5, 1, 0);
            if (i == 3) COND = 4'b0001;
            step();
        end
        lit("wait_release", 6, 1, 0);
        step();
        ack_prog();
        COND = 4'b0000;

        // Wrap and ignored START/ACK
        clear_rom();
        set_word(0, 3'b010, 2'd2, 1'b0, 4'd14);
        set_word(1, 3'b110, 2'd0, 1'b0, 4'd0);
        ack_prog();
        lit("ack_in_idle", 0, 0, 0);
        start_prog();
        lit("wrap_start", 0, 1, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        lit("start_in_run", 14, 1, 0);
        step();
        lit("wrap_15", 15, 1, 0);
        step();
        lit("wrap_to_0", 0, 1, 0);
        COND = 4'b0100;
        step();
        lit("wrap_exit", 1, 1, 0);
        step();
        lit("wrap_done", 0, 0, 1);
        START = 1'b1;
        ACK   = 1'b1;
        step();
        START = 1'b0;
        ACK   = 1'b0;
        lit("no_autostart", 0, 0, 0);
        step();
        lit("no_autostart_hold", 0, 0, 0);
        COND = 4'b0000;

        // CALL at 2 to 12, RET at 12
        clear_rom();
        set_word(2, 3'b100, 2'd0, 1'b0, 4'd12);
        set_word(3, 3'b110, 2'd0, 1'b0, 4'd0);
        set_word(12, 3'b101, 2'd0, 1'b0, 4'd0);
        set_word(13, 3'b110, 2'd0, 1'b0, 4'd0);
        start_prog();
        repeat (2) step();
        lit("call_at2", 2, 1, 0);
        step();
        lit("call_target", 12, 1, 0);
        step();
        lit("after_ret", EXP_AFTER_RET, 1, 0);
        step();
        lit("call_done", 0, 0, 1);
        ack_prog();

        // Asynchronous reset mid-program
        clear_rom();
        set_word(10, 3'b110, 2'd0, 1'b0, 4'd0);
        start_prog();
        repeat (7) step();
        lit("pre_reset", 7, 1, 0);
        #2 RESET_N = 1'b0;
        #1;
        lit("reset_async", 0, 0, 0);
        step();
        step();
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            lit("post_reset_idle", 0, 0, 0);
        end
        start_prog();
        lit("restart", 0, 1, 0);
        repeat (10) step();
        lit("restart_halt", 10, 1, 0);
        step();
        lit("restart_done", 0, 0, 1);
        ack_prog();
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
